// File: rtl/hub75_pkg.sv
// Shared types and geometry for the HUB75 32x32 scan controller.
package hub75_pkg;

   localparam int COLS      = 32;
   localparam int ROW_PAIRS = 16;
   localparam int PIXEL_W   = 3;
   localparam int COL_W     = $clog2(COLS);
   localparam int ROW_W     = $clog2(ROW_PAIRS);

   typedef enum logic [2:0] {
      IDLE,
      PREFETCH,
      SHIFT,
      BLANK,
      LATCH,
      DISPLAY,
      FRAME_END
   } scan_state_t;

endpackage

// File: rtl/hub75_scan_timer.sv
// Loadable down-counter shared by the PREFETCH, BLANK and DISPLAY phases.
module scan_timer
   import hub75_pkg::*;
#(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (cnt != '0)
         cnt <= cnt - 1'b1;
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan scheduler: per row pair it prefetches, shifts COLS pixels,
// blanks, latches and displays; frame-boundary buffer swap via req/ack.
module hub75_scan_ctrl #(
   parameter int COLS         = hub75_pkg::COLS,
   parameter int ROW_PAIRS    = hub75_pkg::ROW_PAIRS,
   parameter int BLANK_CYCLES = 2,
   parameter int DISP_CYCLES  = 26
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  en,
   input  logic [$clog2(ROW_PAIRS+1)-1:0]        row_limit,
   output logic [$clog2(COLS)-1:0]               rd_col,
   output logic [$clog2(ROW_PAIRS)-1:0]          rd_row,
   output logic                                  buf_sel,
   input  logic [hub75_pkg::PIXEL_W-1:0]         rd_data0,
   input  logic [hub75_pkg::PIXEL_W-1:0]         rd_data1,
   input  logic                                  swap_req,
   output logic                                  swap_ack,
   output logic [hub75_pkg::PIXEL_W-1:0]         rgb0,
   output logic [hub75_pkg::PIXEL_W-1:0]         rgb1,
   output logic                                  clk_out,
   output logic                                  latch,
   output logic                                  oe,
   output logic [$clog2(ROW_PAIRS)-1:0]          row_out,
   output logic                                  frame_done
);
   import hub75_pkg::*;

   localparam int CW   = $clog2(COLS);
   localparam int RW   = $clog2(ROW_PAIRS);
   localparam int LW   = $clog2(ROW_PAIRS + 1);
   localparam int TMAX = (BLANK_CYCLES > DISP_CYCLES) ? BLANK_CYCLES : DISP_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);

   scan_state_t   state, nxt;
   logic [LW-1:0] active, limit_clip;
   logic [RW-1:0] row_cnt;
   logic [CW-1:0] col;
   logic          phase;
   logic          tmr_load, tmr_done;
   logic [TW-1:0] tmr_val;
   logic          last_row, shift_end, aborting;

   scan_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   assign limit_clip = (row_limit > LW'(ROW_PAIRS)) ? LW'(ROW_PAIRS) : row_limit;
   assign last_row   = (LW'(row_cnt) == active - LW'(1));
   assign shift_end  = phase && (col == CW'(COLS - 1));
   assign aborting   = (state != IDLE) && !en;

   assign frame_done = (state == FRAME_END) && en;
   assign swap_ack   = frame_done && swap_req;
   assign rd_row     = row_cnt;
   assign rd_col     = (state == SHIFT) ? col + 1'b1 : '0;

   // Timer is loaded on the edge entering a timed state, so it holds N-1 there.
   always_comb begin
      nxt      = state;
      tmr_load = 1'b0;
      tmr_val  = '0;
      if (aborting)
         nxt = IDLE;
      else begin
         case (state)
            IDLE: if (en) begin
               if (limit_clip != '0) begin
                  nxt      = PREFETCH;
                  tmr_load = 1'b1;
                  tmr_val  = TW'(1);
               end else
                  nxt = FRAME_END;
            end
            PREFETCH: if (tmr_done) nxt = SHIFT;
            SHIFT: if (shift_end) begin
               nxt      = BLANK;
               tmr_load = 1'b1;
               tmr_val  = TW'(BLANK_CYCLES - 1);
            end
            BLANK: if (tmr_done) nxt = LATCH;
            LATCH: begin
               nxt      = DISPLAY;
               tmr_load = 1'b1;
               tmr_val  = TW'(DISP_CYCLES - 1);
            end
            DISPLAY: if (tmr_done) begin
               if (last_row)
                  nxt = FRAME_END;
               else begin
                  nxt      = PREFETCH;
                  tmr_load = 1'b1;
                  tmr_val  = TW'(1);
               end
            end
            FRAME_END: nxt = IDLE;
            default:   nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         active  <= '0;
         row_cnt <= '0;
         col     <= '0;
         phase   <= 1'b0;
         buf_sel <= 1'b0;
      end else begin
         state <= nxt;
         if (state == IDLE && en)
            active <= limit_clip;
         if (nxt == IDLE)
            row_cnt <= '0;
         else if (state == DISPLAY && nxt == PREFETCH)
            row_cnt <= row_cnt + 1'b1;
         if (state == SHIFT && nxt == SHIFT) begin
            phase <= ~phase;
            if (phase)
               col <= col + 1'b1;
         end else begin
            phase <= 1'b0;
            col   <= '0;
         end
         if (swap_ack)
            buf_sel <= ~buf_sel;
      end
   end

   // Panel pins are registered from the next state so they line up with it.
   always_ff @(posedge clk) begin
      if (reset) begin
         rgb0    <= '0;
         rgb1    <= '0;
         clk_out <= 1'b0;
         latch   <= 1'b0;
         oe      <= 1'b1;
         row_out <= '0;
      end else begin
         clk_out <= (state == SHIFT) && (nxt == SHIFT) && !phase;
         latch   <= (nxt == LATCH);
         oe      <= (nxt != DISPLAY);
         if (state == LATCH && nxt == DISPLAY)
            row_out <= row_cnt;
         if (aborting) begin
            rgb0 <= '0;
            rgb1 <= '0;
         end else if ((state == PREFETCH && tmr_done) || (state == SHIFT && phase)) begin
            rgb0 <= rd_data0;
            rgb1 <= rd_data1;
         end
      end
   end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Scoreboard bench: a frame-level model queues expected panel events, a monitor checks them.
module tb_hub75_scan_ctrl;
   import hub75_pkg::*;

   localparam int K_SHIFT = 0;
   localparam int K_LATCH = 1;
   localparam int K_DISP  = 2;
   localparam int K_FRAME = 3;
   localparam int ROW_CYC = 95;

   typedef struct {
      int       kind;
      int       row;
      int       col;
      logic [2:0] p0;
      logic [2:0] p1;
      bit       swap;
      bit       bsel;
      int       len;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset, en, swap_req;
   logic [4:0] row_limit;
   logic [4:0] rd_col;
   logic [3:0] rd_row, row_out;
   logic       buf_sel, swap_ack, clk_out, latch, oe, frame_done;
   logic [2:0] rd_data0 = '0, rd_data1 = '0, rgb0, rgb1;

   logic [2:0] fb0 [0:1][0:15][0:31];
   logic [2:0] fb1 [0:1][0:15][0:31];

   ev_t q[$];
   int  vectors = 0, miscompares = 0;
   bit  mon_on = 1'b0, model_buf = 1'b0;
   int  cyc = 0, last_fd = -1, oe_run = 0;
   logic prev_clk = 1'b0, prev_oe = 1'b1;

   hub75_scan_ctrl #(
      .COLS(32), .ROW_PAIRS(16), .BLANK_CYCLES(2), .DISP_CYCLES(26)
   ) dut (
      .clk(clk), .reset(reset), .en(en), .row_limit(row_limit),
      .rd_col(rd_col), .rd_row(rd_row), .buf_sel(buf_sel),
      .rd_data0(rd_data0), .rd_data1(rd_data1),
      .swap_req(swap_req), .swap_ack(swap_ack),
      .rgb0(rgb0), .rgb1(rgb1), .clk_out(clk_out), .latch(latch),
      .oe(oe), .row_out(row_out), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   // Framebuffer with one cycle of read latency.
   always @(posedge clk) begin
      rd_data0 <= fb0[buf_sel][rd_row][rd_col];
      rd_data1 <= fb1[buf_sel][rd_row][rd_col];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic pop_ev(input int kind, output ev_t e, output bit ok);
      ok = 1'b0;
      if (q.size() == 0) begin
         vectors++;
         miscompares++;
         $display("FAIL unexpected_event: kind %0d seen, expected none (cycle %0d)", kind, cyc);
      end else begin
         e = q.pop_front();
         chk("event_kind", kind, e.kind);
         ok = (kind == e.kind);
      end
   endtask

   always @(negedge clk) begin
      ev_t e;
      bit  ok;
      cyc++;
      if (!mon_on) begin
         last_fd = -1;
         oe_run  = 0;
      end else begin
         if (!oe) oe_run++;
         if (clk_out && !prev_clk) begin
            pop_ev(K_SHIFT, e, ok);
            if (ok) begin
               chk("shift_rgb0", rgb0, e.p0);
               chk("shift_rgb1", rgb1, e.p1);
               chk("shift_rd_row", rd_row, e.row);
               chk("shift_oe", oe, 1);
            end
         end
         if (latch) begin
            pop_ev(K_LATCH, e, ok);
            if (ok) begin
               chk("latch_rd_row", rd_row, e.row);
               chk("latch_oe", oe, 1);
            end
         end
         if (oe && !prev_oe) begin
            pop_ev(K_DISP, e, ok);
            if (ok) begin
               chk("disp_row_out", row_out, e.row);
               chk("disp_len", oe_run, 26);
            end
            oe_run = 0;
         end
         if (frame_done) begin
            pop_ev(K_FRAME, e, ok);
            if (ok) begin
               chk("frame_swap_ack", swap_ack, e.swap);
               chk("frame_buf_sel", buf_sel, e.bsel);
               chk("frame_oe", oe, 1);
               if (last_fd >= 0) chk("frame_len", cyc - last_fd, e.len);
            end
            last_fd = cyc;
         end
      end
      prev_clk = clk_out;
      prev_oe  = oe;
   end

   task automatic wait_fd(input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!frame_done && n < budget);
      if (!frame_done) begin
         vectors++;
         miscompares++;
         $display("FAIL frame_done_timeout: none within %0d cycles, expected a pulse", budget);
      end
   endtask

   task automatic wait_cond(input int which, input int budget);
      int  n = 0;
      bit  hit;
      do begin
         @(negedge clk);
         n++;
         case (which)
            0:       hit = (clk_out == 1'b1);
            1:       hit = (latch == 1'b1);
            default: hit = (oe == 1'b0);
         endcase
      end while (!hit && n < budget);
      if (!hit) begin
         vectors++;
         miscompares++;
         $display("FAIL wait_timeout: condition %0d not seen in %0d cycles, expected it", which, budget);
      end
   endtask

   // Entered in an IDLE cycle with en=1; the model expands one whole frame.
   task automatic frame(input int lim, input bit swp, input int mid);
      int a;
      if (lim >= 0) row_limit = 5'(lim);
      swap_req = swp;
      a = (row_limit > 5'd16) ? 16 : int'(row_limit);
      for (int r = 0; r < a; r++) begin
         for (int c = 0; c < 32; c++)
            q.push_back('{K_SHIFT, r, c, fb0[model_buf][r][c], fb1[model_buf][r][c], 1'b0, 1'b0, 0});
         q.push_back('{K_LATCH, r, 0, 3'd0, 3'd0, 1'b0, 1'b0, 0});
         q.push_back('{K_DISP, r, 0, 3'd0, 3'd0, 1'b0, 1'b0, 0});
      end
      q.push_back('{K_FRAME, 0, 0, 3'd0, 3'd0, swp, model_buf, ROW_CYC * a + 2});
      if (swp) model_buf = ~model_buf;
      if (mid >= 0) begin
         repeat (300) @(posedge clk);
         #1 row_limit = 5'(mid);
      end
      wait_fd(2000);
      @(posedge clk);
      #1 chk("queue_drained", q.size(), 0);
   endtask

   initial begin
      for (int b = 0; b < 2; b++)
         for (int r = 0; r < 16; r++)
            for (int c = 0; c < 32; c++) begin
               fb0[b][r][c] = 3'($urandom_range(0, 7));
               fb1[b][r][c] = 3'($urandom_range(0, 7));
            end
      reset = 1'b1; en = 1'b1; row_limit = 5'd16; swap_req = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_oe", oe, 1);
      chk("rst_clk_out", clk_out, 0);
      chk("rst_latch", latch, 0);
      chk("rst_rgb0", rgb0, 0);
      chk("rst_rgb1", rgb1, 0);
      chk("rst_row_out", row_out, 0);
      chk("rst_buf_sel", buf_sel, 0);
      chk("rst_swap_ack", swap_ack, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_rd_col", rd_col, 0);
      chk("rst_rd_row", rd_row, 0);
      reset = 1'b0;
      mon_on = 1'b1;

      frame(16, 1'b0, -1);
      frame(4, 1'b0, -1);
      frame(-1, 1'b0, -1);
      frame(16, 1'b0, 8);
      frame(-1, 1'b0, -1);
      frame(-1, 1'b1, -1);
      frame(-1, 1'b1, -1);
      frame(2, 1'b1, -1);
      frame(0, 1'b0, -1);
      frame(0, 1'b1, -1);
      frame(20, 1'b0, -1);
      for (int i = 0; i < 6; i++)
         frame(int'($urandom_range(0, 20)), 1'($urandom_range(0, 1)), -1);

      // Abort by en in SHIFT of row 1.
      mon_on = 1'b0;
      row_limit = 5'd16;
      swap_req = 1'b0;
      wait_cond(1, 200);
      wait_cond(0, 200);
      en = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_oe", oe, 1);
      chk("abort_clk_out", clk_out, 0);
      chk("abort_latch", latch, 0);
      chk("abort_rgb0", rgb0, 0);
      chk("abort_rgb1", rgb1, 0);
      chk("abort_rd_row", rd_row, 0);
      chk("abort_frame_done", frame_done, 0);
      chk("abort_swap_ack", swap_ack, 0);
      repeat (4) begin
         @(negedge clk);
         chk("idle_oe", oe, 1);
         chk("idle_frame_done", frame_done, 0);
      end

      // Ensure bank 1 is selected so reset has something to clear.
      en = 1'b1;
      if (!model_buf) begin
         row_limit = 5'd0;
         swap_req = 1'b1;
         wait_fd(10);
         chk("swap_ack_short_frame", swap_ack, 1);
         @(posedge clk);
         #1;
         swap_req = 1'b0;
         row_limit = 5'd16;
         model_buf = 1'b1;
      end
      chk("buf_sel_before_reset", buf_sel, 1);
      wait_cond(1, 300);
      wait_cond(1, 300);
      wait_cond(2, 50);
      chk("row_out_before_reset", row_out, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_oe", oe, 1);
      chk("mid_rst_clk_out", clk_out, 0);
      chk("mid_rst_latch", latch, 0);
      chk("mid_rst_buf_sel", buf_sel, 0);
      chk("mid_rst_row_out", row_out, 0);
      chk("mid_rst_frame_done", frame_done, 0);
      chk("mid_rst_swap_ack", swap_ack, 0);
      chk("mid_rst_rd_col", rd_col, 0);
      chk("mid_rst_rd_row", rd_row, 0);
      chk("mid_rst_rgb0", rgb0, 0);
      reset = 1'b0;
      en = 1'b0;
      repeat (2) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
